// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - raster timing generator (hsync/vsync/de/x/y/sof)
// Define LCD_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module lcd_timing_gen #(
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       sof
`ifdef LCD_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic       HS_ACT     = (HS_POL != 0);
    localparam logic       VS_ACT     = (VS_POL != 0);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       de_q, de_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       sof_q, sof_d;
    logic       at_origin;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (ce) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // Decode from the next position so every flag lands in the same cycle as x/y.
    always_comb begin
        at_origin = (h_d == 10'd0) && (v_d == 10'd0);
        de_d      = (h_d < H_ACT_END) && (v_d < V_ACT_END);
        hsync_d   = ((h_d >= HS_FIRST) && (h_d <= HS_LAST)) ? HS_ACT : ~HS_ACT;
        vsync_d   = ((v_d >= VS_FIRST) && (v_d <= VS_LAST)) ? VS_ACT : ~VS_ACT;
        sof_d     = at_origin;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q     <= H_LAST;
            v_q     <= V_LAST;
            de_q    <= 1'b0;
            hsync_q <= ~HS_ACT;
            vsync_q <= ~VS_ACT;
            sof_q   <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            sof_q   <= sof_d;
        end
    end

`ifdef LCD_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Only a ce edge can move the position, so this counts entries into (0,0).
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (ce && at_origin) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign x     = h_q;
    assign y     = v_q;
    assign de    = de_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign sof   = sof_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb/tb_lcd_timing_gen.sv - bench for lcd_timing_gen (small-raster vectors/random plus default-raster line)
module tb_lcd_timing_gen;

    localparam int SH_ACT = 8, SH_FP = 2, SH_SY = 3, SH_BP = 2;
    localparam int SV_ACT = 5, SV_FP = 1, SV_SY = 2, SV_BP = 1;
    localparam int SHT = SH_ACT + SH_FP + SH_SY + SH_BP;
    localparam int SVT = SV_ACT + SV_FP + SV_SY + SV_BP;
    localparam int SNP = SHT * SVT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       s_rst, s_ce, s_hs, s_vs, s_de, s_sof;
    logic [9:0] s_x, s_y;
    logic       d_rst, d_ce, d_hs, d_vs, d_de, d_sof;
    logic [9:0] d_x, d_y;
`ifdef LCD_TIMING_FRAME_CNT_EN
    logic [15:0] s_fc, d_fc;
`endif

    lcd_timing_gen #(
        .H_ACTIVE(SH_ACT), .H_FP(SH_FP), .H_SYNC(SH_SY), .H_BP(SH_BP),
        .V_ACTIVE(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SY), .V_BP(SV_BP),
        .HS_POL(0), .VS_POL(1)
    ) dut_s (
        .clk(clk), .reset(s_rst), .ce(s_ce),
        .hsync(s_hs), .vsync(s_vs), .de(s_de), .x(s_x), .y(s_y), .sof(s_sof)
`ifdef LCD_TIMING_FRAME_CNT_EN
        , .frame_cnt(s_fc)
`endif
    );

    lcd_timing_gen dut_d (
        .clk(clk), .reset(d_rst), .ce(d_ce),
        .hsync(d_hs), .vsync(d_vs), .de(d_de), .x(d_x), .y(d_y), .sof(d_sof)
`ifdef LCD_TIMING_FRAME_CNT_EN
        , .frame_cnt(d_fc)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference: the raster is a linear pixel index p; x/y are its mod/div by line length.
    int p;
    int fc;

    task automatic model_step(input logic rst, input logic ce);
        if (rst) begin
            p  = SNP - 1;
            fc = 0;
        end else if (ce) begin
            p = (p + 1) % SNP;
            if (p == 0) fc = (fc + 1) % 65536;
        end
    endtask

    task automatic model_compare(input string tag);
        int ex, ey;
        ex = p % SHT;
        ey = p / SHT;
        check({tag, " x"}, int'(s_x), ex);
        check({tag, " y"}, int'(s_y), ey);
        check({tag, " de"}, int'(s_de), int'(ex < SH_ACT && ey < SV_ACT));
        check({tag, " hsync"}, int'(s_hs),
              int'(!(ex >= SH_ACT + SH_FP && ex < SH_ACT + SH_FP + SH_SY)));
        check({tag, " vsync"}, int'(s_vs),
              int'(ey >= SV_ACT + SV_FP && ey < SV_ACT + SV_FP + SV_SY));
        check({tag, " sof"}, int'(s_sof), int'(p == 0));
`ifdef LCD_TIMING_FRAME_CNT_EN
        check({tag, " frame_cnt"}, int'(s_fc), fc);
`endif
    endtask

    typedef struct {
        logic rst;
        logic ce;
        int   ex;
        int   ey;
        logic ede;
        logic ehs;
        logic evs;
        logic esof;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int sof_seen, de_cnt, hs_cnt, hs_min, hs_max;

        vecs[0] = '{1'b1, 1'b1, 14, 8, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 14, 8, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1,  0, 0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0,  0, 0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1,  1, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1,  2, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 14, 8, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1,  0, 0, 1'b1, 1'b1, 1'b0, 1'b1};

        s_rst = 1'b1; s_ce = 1'b0;
        d_rst = 1'b1; d_ce = 1'b1;
        p = SNP - 1; fc = 0;

        for (int i = 0; i < 8; i++) begin
            s_rst = vecs[i].rst;
            s_ce  = vecs[i].ce;
            tick();
            model_step(s_rst, s_ce);
            check($sformatf("vec%0d x", i), int'(s_x), vecs[i].ex);
            check($sformatf("vec%0d y", i), int'(s_y), vecs[i].ey);
            check($sformatf("vec%0d de", i), int'(s_de), int'(vecs[i].ede));
            check($sformatf("vec%0d hsync", i), int'(s_hs), int'(vecs[i].ehs));
            check($sformatf("vec%0d vsync", i), int'(s_vs), int'(vecs[i].evs));
            check($sformatf("vec%0d sof", i), int'(s_sof), int'(vecs[i].esof));
        end

        for (int i = 0; i < 4000; i++) begin
            s_rst = ($urandom_range(0, 299) == 0);
            s_ce  = ($urandom_range(0, 3) != 0);
            tick();
            model_step(s_rst, s_ce);
            model_compare("rand");
        end

        // Two full frames from reset with ce held high.
        s_rst = 1'b1; s_ce = 1'b1;
        tick();
        model_step(1'b1, 1'b1);
        s_rst = 1'b0;
        sof_seen = 0;
        for (int i = 0; i < 2 * SNP; i++) begin
            tick();
            model_step(1'b0, 1'b1);
            if (s_sof) sof_seen++;
        end
        check("two-frame sof count", sof_seen, 2);
`ifdef LCD_TIMING_FRAME_CNT_EN
        check("two-frame frame_cnt", int'(s_fc), 2);
`endif
        model_compare("two-frame end");

        // Default raster: reset state and the first line.
        d_rst = 1'b1; d_ce = 1'b1;
        tick();
        tick();
        check("dflt reset x", int'(d_x), 524);
        check("dflt reset y", int'(d_y), 285);
        check("dflt reset de", int'(d_de), 0);
        check("dflt reset hsync", int'(d_hs), 1);
        check("dflt reset vsync", int'(d_vs), 1);
        check("dflt reset sof", int'(d_sof), 0);

        d_rst = 1'b0;
        tick();
        check("dflt first x", int'(d_x), 0);
        check("dflt first y", int'(d_y), 0);
        check("dflt first de", int'(d_de), 1);
        check("dflt first sof", int'(d_sof), 1);
`ifdef LCD_TIMING_FRAME_CNT_EN
        check("dflt first frame_cnt", int'(d_fc), 1);
`endif
        de_cnt = 1; hs_cnt = 0; hs_min = 1024; hs_max = -1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (d_de) de_cnt++;
            if (i == 0) check("dflt sof pulse", int'(d_sof), 0);
        end
        check("dflt x at hold", int'(d_x), 100);

        d_ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold x", int'(d_x), 100);
            check("hold y", int'(d_y), 0);
            check("hold hsync", int'(d_hs), 1);
            check("hold vsync", int'(d_vs), 1);
            check("hold de", int'(d_de), 1);
        end
        d_ce = 1'b1;
        tick();
        check("resume x", int'(d_x), 101);
        if (d_de) de_cnt++;
        for (int i = 0; i < 423; i++) begin
            tick();
            if (d_de) de_cnt++;
            if (!d_hs) begin
                hs_cnt++;
                if (int'(d_x) < hs_min) hs_min = int'(d_x);
                if (int'(d_x) > hs_max) hs_max = int'(d_x);
            end
            check("line0 vsync", int'(d_vs), 1);
        end
        check("line0 end x", int'(d_x), 524);
        check("line0 de count", de_cnt, 480);
        check("line0 hsync count", hs_cnt, 41);
        check("line0 hsync first x", hs_min, 482);
        check("line0 hsync last x", hs_max, 522);
        tick();
        check("line1 x", int'(d_x), 0);
        check("line1 y", int'(d_y), 1);
        check("line1 sof", int'(d_sof), 0);

        d_rst = 1'b1;
        tick();
        check("dflt midreset x", int'(d_x), 524);
        check("dflt midreset y", int'(d_y), 285);
        d_rst = 1'b0;
        tick();
        check("dflt after midreset sof", int'(d_sof), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
